// File: rtl/seq_piso_feeder.sv
// Parallel-in/serial-out feeder for a serial sequence detector.
// A one-word pending buffer lets frames run back-to-back with no idle bit between them.
module seq_piso_feeder #(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             out,
   output logic             bit_valid,
   output logic             frame_done,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] sreg, sreg_nx;
   logic [WIDTH-1:0] pend, pend_nx;
   logic             pend_full, pend_full_nx;
   logic [CW-1:0]    cnt, cnt_nx;
   logic             accept;
   logic             last_bit;
   logic [WIDTH-1:0] sreg_adv;
   logic             head_bit;

   // Ready is forced low during reset so a word presented on a reset edge is never taken.
   assign load_ready = ~pend_full & ~reset;
   assign accept     = load_valid & load_ready;
   assign last_bit   = (cnt == LAST);

   assign sreg_adv = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
   assign head_bit = MSB_FIRST ? sreg[WIDTH-1] : sreg[0];

   always_comb begin
      state_nx     = state;
      sreg_nx      = sreg;
      pend_nx      = pend;
      pend_full_nx = pend_full;
      cnt_nx       = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               sreg_nx  = data_in;
               cnt_nx   = '0;
               state_nx = SHIFT;
            end
         end
         SHIFT: begin
            if (!last_bit) begin
               sreg_nx = sreg_adv;
               cnt_nx  = cnt + 1'b1;
               if (accept) begin
                  pend_nx      = data_in;
                  pend_full_nx = 1'b1;
               end
            end else if (pend_full) begin
               // Queued word takes priority; ready was low so nothing new is taken here.
               sreg_nx      = pend;
               pend_nx      = '0;
               pend_full_nx = 1'b0;
               cnt_nx       = '0;
            end else if (accept) begin
               sreg_nx = data_in;
               cnt_nx  = '0;
            end else begin
               sreg_nx  = '0;
               cnt_nx   = '0;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         sreg      <= '0;
         pend      <= '0;
         pend_full <= 1'b0;
         cnt       <= '0;
      end else begin
         state     <= state_nx;
         sreg      <= sreg_nx;
         pend      <= pend_nx;
         pend_full <= pend_full_nx;
         cnt       <= cnt_nx;
      end
   end

   assign busy       = (state == SHIFT);
   assign bit_valid  = busy;
   assign frame_done = busy & last_bit;
   assign out        = busy ? head_bit : IDLE_BIT;

endmodule

// File: tb/tb_seq_piso_feeder.sv
// Bench for seq_piso_feeder: directed frames plus random traffic against a word-level model,
// with MSB-first and LSB-first instances driven by the same stimulus.
module tb_seq_piso_feeder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] d = '0;
   logic       lv = 1'b0;

   logic lr_m, out_m, bv_m, fd_m, busy_m;
   logic lr_l, out_l, bv_l, fd_l, busy_l;

   always #5 clk = ~clk;

   seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk(clk), .reset(reset), .data_in(d), .load_valid(lv), .load_ready(lr_m),
      .out(out_m), .bit_valid(bv_m), .frame_done(fd_m), .busy(busy_m));

   seq_piso_feeder #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk(clk), .reset(reset), .data_in(d), .load_valid(lv), .load_ready(lr_l),
      .out(out_l), .bit_valid(bv_l), .frame_done(fd_l), .busy(busy_l));

   int nchk = 0;
   int nerr = 0;

   // Word-level model: current frame word plus bits remaining, and a one-word queue.
   int         rem = 0;
   logic [7:0] cw = '0;
   logic [7:0] pw = '0;
   bit         pv = 1'b0;
   logic [3:0] dh = '0;   // last four bits seen by a 1101 detector fed from out_m

   logic s_out_m, s_out_l, s_bv, s_fd, s_busy, s_lr, s_det;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_edge();
      bit acc;
      dh = reset ? 4'b0 : {dh[2:0], s_out_m};
      if (reset) begin
         rem = 0;
         pv  = 1'b0;
      end else begin
         acc = lv && !pv;
         if (rem > 0) rem--;
         if (rem == 0) begin
            if (pv) begin
               cw = pw; pv = 1'b0; rem = 8;
            end else if (acc) begin
               cw = d; rem = 8;
            end
         end else if (acc) begin
            pw = d; pv = 1'b1;
         end
      end
   endtask

   task automatic tick();
      logic e_om, e_ol;
      @(negedge clk);
      s_out_m = out_m; s_out_l = out_l; s_bv = bv_m; s_fd = fd_m;
      s_busy = busy_m; s_lr = lr_m; s_det = (dh == 4'b1101);
      e_om = 1'b0;
      e_ol = 1'b0;
      if (rem > 0) begin
         e_om = cw[rem-1];
         e_ol = cw[8-rem];
      end
      chk("out_m", out_m, e_om);
      chk("out_l", out_l, e_ol);
      chk("bv_m", bv_m, rem > 0);
      chk("bv_l", bv_l, rem > 0);
      chk("fd_m", fd_m, rem == 1);
      chk("fd_l", fd_l, rem == 1);
      chk("busy_m", busy_m, rem > 0);
      chk("busy_l", busy_l, rem > 0);
      chk("lr_m", lr_m, !reset && !pv);
      chk("lr_l", lr_l, !reset && !pv);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      logic [7:0]  w;
      logic [15:0] w16;

      @(posedge clk); #1;
      tick();
      chk("rst_lr", s_lr, 0); chk("rst_bv", s_bv, 0); chk("rst_out", s_out_m, 0);

      // single frame MSB-first
      reset = 1'b0; lv = 1'b1; d = 8'hD5;
      tick();
      chk("rel_lr", s_lr, 1);
      lv = 1'b0; w = 8'hD5;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_out", s_out_m, w[7-i]); chk("t1_fd", s_fd, i == 7); chk("t1_busy", s_busy, 1);
      end
      tick();
      chk("t1_end_bv", s_bv, 0); chk("t1_end_busy", s_busy, 0); chk("t1_end_out", s_out_m, 0);

      // LSB-first instance
      lv = 1'b1; d = 8'h0B;
      tick();
      lv = 1'b0; w = 8'h0B;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t5_out_l", s_out_l, w[i]);
      end
      tick();

      // back-to-back through the pending buffer
      lv = 1'b1; d = 8'hD0;
      tick();
      d = 8'h0D; w16 = 16'hD00D;
      for (int j = 0; j < 16; j++) begin
         tick();
         if (j == 0) lv = 1'b0;
         chk("t2_out", s_out_m, w16[15-j]); chk("t2_bv", s_bv, 1);
         chk("t2_fd", s_fd, (j == 7) || (j == 15));
         chk("t2_lr", s_lr, !((j >= 1) && (j <= 7)));
      end
      tick();
      chk("t2_end_bv", s_bv, 0);

      // bypass on the last-bit edge
      lv = 1'b1; d = 8'h3C;
      tick();
      lv = 1'b0; w16 = 16'h3CFF;
      for (int j = 0; j < 16; j++) begin
         if (j == 7) begin lv = 1'b1; d = 8'hFF; end
         tick();
         if (j == 7) begin lv = 1'b0; chk("t3_fd", s_fd, 1); end
         chk("t3_out", s_out_m, w16[15-j]); chk("t3_bv", s_bv, 1); chk("t3_lr", s_lr, 1);
      end
      tick();
      chk("t3_end_bv", s_bv, 0);

      // reset mid-frame drops both the active and pending word
      lv = 1'b1; d = 8'hAA;
      tick();
      d = 8'h55;
      tick();
      lv = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int k = 0; k < 12; k++) begin
         tick();
         chk("t4_bv", s_bv, 0); chk("t4_fd", s_fd, 0); chk("t4_busy", s_busy, 0);
         chk("t4_out", s_out_m, 0);
      end

      // detector sees 1101 twice in 8'hDB (overlap)
      lv = 1'b1; d = 8'hDB;
      tick();
      lv = 1'b0;
      for (int j = 0; j < 12; j++) begin
         tick();
         chk("t6_det", s_det, (j == 4) || (j == 7));
      end

      // random traffic; upstream holds a word it could not hand over
      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         if (!(lv && pv)) begin
            lv = $urandom_range(0, 1);
            d  = 8'($urandom);
         end
         tick();
      end
      reset = 1'b0; lv = 1'b0;
      tick();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/seq_piso_feeder.md
Name: seq_piso_feeder

Overview:
- Parallel-in/serial-out feeder that sits directly upstream of the overlapping Moore 1101 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and presents them one bit per clock on `out`, which drives the detector's serial `in`.
- A one-word holding buffer allows gapless back-to-back frames.
- Between frames, `out` is held at IDLE_BIT so the detector sees a defined, non-matching level.

Parameters:
- WIDTH, 8: bits per word; legal range WIDTH >= 2.
- MSB_FIRST, 1: 1 = data_in[WIDTH-1] is sent first; 0 = data_in[0] is sent first.
- IDLE_BIT, 0: level driven on `out` when no bit is valid.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- data_in  input  WIDTH  parallel word to serialize.
- load_valid  input  1  data_in is valid.
- load_ready  output  1  feeder can accept a word this cycle.
- out  output  1  serial bit to the detector's `in`.
- bit_valid  output  1  `out` carries a frame bit this cycle.
- frame_done  output  1  high during the cycle `out` carries the last bit of a frame.
- busy  output  1  a frame is being shifted.

Behaviour:
- Reset is synchronous and active-high; only an edge with reset=1 takes effect.
  - After that edge: state=IDLE, shift register cleared, pending buffer empty, bit count=0.
  - Outputs: out=IDLE_BIT, bit_valid=0, frame_done=0, busy=0.
  - load_ready=0 while reset is high; load_ready=1 on the first cycle after reset is released.
- Handshake:
  - A word transfers on an edge where load_valid=1 and load_ready=1.
  - load_valid while load_ready=0 is ignored; upstream holds data_in and load_valid.
  - load_ready is the inverse of the registered pending-full flag, so it is always 1 in IDLE.
- State machine: two states, IDLE and SHIFT.
  - IDLE, accept on edge N: data_in loads straight into the shift register, bit count=0, state goes to SHIFT.
  - The first bit appears on `out` with bit_valid=1 immediately after edge N. Latency is one edge.
  - SHIFT, not last bit: the shift register advances one position per edge, bit count increments.
  - SHIFT, accept while pending is empty and not the last bit: the word goes into pending, and load_ready=0 from the next cycle.
  - SHIFT, last-bit edge (bit count=WIDTH-1), checked in priority order:
    - pending full: pending moves to the shift register, pending clears, bit count=0, stay in SHIFT. load_ready returns to 1 on the following cycle. A load_valid on this edge is not accepted, because load_ready was 0.
    - pending empty with an accept on this edge: bypass. data_in loads straight into the shift register, stay in SHIFT, no idle cycle.
    - otherwise: go to IDLE; out=IDLE_BIT and bit_valid=0 on the next cycle.
- Decoded outputs:
  - frame_done = bit_valid and (bit count == WIDTH-1).
  - busy = (state == SHIFT).
  - Both are decoded only from registered state, so they are glitch-free.
- Bit-level timing:
  - Each bit is held for exactly one cycle.
  - Back-to-back frames give a continuous run of bit_valid with no bubble.
- Reset mid-frame: the in-progress frame and the pending word are both discarded. No frame_done is produced and no partial bits follow.
- Reset and load_valid on the same edge: reset wins and the word is not accepted.

Test Plan:
1. Single frame. Release reset, then load 8'hD5 with MSB_FIRST=1.
   - out = 1,1,0,1,0,1,0,1 on 8 consecutive cycles with bit_valid=1 and busy=1.
   - frame_done=1 only on the 8th cycle.
   - Next cycle: out=0, bit_valid=0, busy=0.
2. Back-to-back. Hold load_valid with 8'hD0, then 8'h0D.
   - Word 1 is accepted at edge 0 and word 2 at edge 1; load_ready=0 from cycle 2 through cycle 8 and returns to 1 at cycle 9.
   - 16 contiguous valid bits: 11010000 00001101, with frame_done on bits 8 and 16.
3. Bypass. With pending empty, present 8'hFF only during the cycle frame_done=1.
   - The word is accepted and the first bit of 8'hFF follows on the next cycle with no gap.
   - load_ready stays 1 throughout.
4. Mid-frame reset.
   - Load 8'hAA and queue 8'h55 in pending.
   - Assert reset for one edge after 3 bits have been sent.
   - Next cycle: out=IDLE_BIT, bit_valid=0, busy=0, frame_done never asserted. 8'h55 is never transmitted.
5. LSB-first. With MSB_FIRST=0, load 8'h0B.
   - out = 1,1,0,1,0,0,0,0.
6. Integration with the detector. Drive 8'hDB (bit stream 1,1,0,1,1,0,1,1) into the Moore 1101 overlapping detector.
   - Detector out=1 for one cycle after feeder bit 4, and again one cycle after feeder bit 7 (overlap).
   - Detector out=0 elsewhere, including while the feeder idles at 0.
